cr_had_trace_ctrl: RTL and testbench

HAD control-path responder for trace requests. It consumes trace_ctrl_req (one pulse per traced, normally retired instruction), counts down a debugger-programmed trace counter, and at zero requests debug-mode entry from the core. It then holds in debug until the debugger requests exit, and handshakes the exit. Sits between the HAD trace block and the core debug-request/dbgon interface; its debug request feeds had_core_dbg_mode_req.

---
 rtl/cr_had_pkg.sv | 14 +
 rtl/cr_had_trace_cnt.sv | 27 ++
 rtl/cr_had_trace_ctrl.sv | 89 ++++++++
 tb/tb_cr_had_trace_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cr_had_pkg.sv
// Shared definitions for the HAD trace control path: FSM encoding and the
// default trace counter width.
package cr_had_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_DEBUG = 2'b10,
    ST_EXIT  = 2'b11
  } had_state_e;

endpackage

// File: rtl/cr_had_trace_cnt.sv
// Loadable down-counter for trace stepping; saturates at zero and flags it.
module cr_had_trace_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             cpuclk,
  input  logic             cpurst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             eq0
);

  assign eq0 = (cnt == '0);

  // A load always wins; a decrement at zero is dropped so the count never wraps.
  always_ff @(posedge cpuclk or posedge cpurst) begin
    if (cpurst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !eq0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/cr_had_trace_ctrl.sv
// Trace responder: counts traced retirements, requests debug entry at zero,
// then handshakes the debugger-initiated exit with the core.
module cr_had_trace_ctrl
  import cr_had_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             cpuclk,
  input  logic             cpurst,
  input  logic             trace_ctrl_req,
  input  logic             regs_trace_cnt_sel,
  input  logic [CNT_W-1:0] regs_xx_wdata,
  input  logic             regs_exit_dbg,
  input  logic             iu_yy_xx_dbgon,
  output logic             ctrl_trace_dbg_req,
  output logic             ctrl_trace_exit_req,
  output logic [CNT_W-1:0] trace_regs_counter,
  output logic             trace_regs_reason_trace,
  output logic             ctrl_trace_busy
);

  had_state_e state, next_state;
  logic       cnt_eq0;
  logic       set_reason, clr_reason;

  cr_had_trace_cnt #(.CNT_W(CNT_W)) u_cnt (
    .cpuclk   (cpuclk),
    .cpurst   (cpurst),
    .load     (regs_trace_cnt_sel),
    .load_val (regs_xx_wdata),
    .dec      (trace_ctrl_req && (state == ST_IDLE)),
    .cnt      (trace_regs_counter),
    .eq0      (cnt_eq0)
  );

  always_ff @(posedge cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state                   <= ST_IDLE;
      trace_regs_reason_trace <= 1'b0;
    end else begin
      state <= next_state;
      if (set_reason) begin
        trace_regs_reason_trace <= 1'b1;
      end else if (clr_reason) begin
        trace_regs_reason_trace <= 1'b0;
      end
    end
  end

  // External debug entry beats a trace hit; a counter write in the same cycle
  // suppresses the trace hit entirely.
  always_comb begin
    next_state = state;
    set_reason = 1'b0;
    clr_reason = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (iu_yy_xx_dbgon) begin
          next_state = ST_DEBUG;
        end else if (trace_ctrl_req && cnt_eq0 && !regs_trace_cnt_sel) begin
          next_state = ST_REQ;
        end
      end
      ST_REQ: begin
        if (iu_yy_xx_dbgon) begin
          next_state = ST_DEBUG;
          set_reason = 1'b1;
        end
      end
      ST_DEBUG: begin
        if (regs_exit_dbg) begin
          next_state = ST_EXIT;
        end
      end
      ST_EXIT: begin
        if (!iu_yy_xx_dbgon) begin
          next_state = ST_IDLE;
          clr_reason = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign ctrl_trace_dbg_req  = (state == ST_REQ);
  assign ctrl_trace_exit_req = (state == ST_EXIT);
  assign ctrl_trace_busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_cr_had_trace_ctrl.sv
// Bench for cr_had_trace_ctrl: directed handshakes plus randomized traffic
// from a simple core model, checked against a flag-based reference model.
module tb_cr_had_trace_ctrl;

  localparam int CNT_W = 8;

  logic             cpuclk = 1'b0;
  logic             cpurst;
  logic             trace_ctrl_req;
  logic             regs_trace_cnt_sel;
  logic [CNT_W-1:0] regs_xx_wdata;
  logic             regs_exit_dbg;
  logic             iu_yy_xx_dbgon;
  logic             ctrl_trace_dbg_req;
  logic             ctrl_trace_exit_req;
  logic [CNT_W-1:0] trace_regs_counter;
  logic             trace_regs_reason_trace;
  logic             ctrl_trace_busy;

  int total = 0;
  int bad   = 0;

  // Reference model: which handshake phase we are in, as independent flags.
  int m_cnt;
  bit m_requesting, m_in_debug, m_exiting, m_reason;
  bit core_dbgon;

  always #5 cpuclk = ~cpuclk;

  cr_had_trace_ctrl #(.CNT_W(CNT_W)) dut (
    .cpuclk                  (cpuclk),
    .cpurst                  (cpurst),
    .trace_ctrl_req          (trace_ctrl_req),
    .regs_trace_cnt_sel      (regs_trace_cnt_sel),
    .regs_xx_wdata           (regs_xx_wdata),
    .regs_exit_dbg           (regs_exit_dbg),
    .iu_yy_xx_dbgon          (iu_yy_xx_dbgon),
    .ctrl_trace_dbg_req      (ctrl_trace_dbg_req),
    .ctrl_trace_exit_req     (ctrl_trace_exit_req),
    .trace_regs_counter      (trace_regs_counter),
    .trace_regs_reason_trace (trace_regs_reason_trace),
    .ctrl_trace_busy         (ctrl_trace_busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    bit idle;
    idle = !(m_requesting || m_in_debug || m_exiting);
    checkOutput({tag, ".dbg_req"}, 32'(ctrl_trace_dbg_req), 32'(m_requesting));
    checkOutput({tag, ".exit_req"}, 32'(ctrl_trace_exit_req), 32'(m_exiting));
    checkOutput({tag, ".counter"}, 32'(trace_regs_counter), 32'(m_cnt));
    checkOutput({tag, ".reason"}, 32'(trace_regs_reason_trace), 32'(m_reason));
    checkOutput({tag, ".busy"}, 32'(ctrl_trace_busy), 32'(!idle));
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic modelStep();
    bit idle;
    idle = !(m_requesting || m_in_debug || m_exiting);
    if (idle) begin
      if (iu_yy_xx_dbgon) m_in_debug = 1;
      else if (trace_ctrl_req && m_cnt == 0 && !regs_trace_cnt_sel) m_requesting = 1;
    end else if (m_requesting) begin
      if (iu_yy_xx_dbgon) begin
        m_requesting = 0;
        m_in_debug   = 1;
        m_reason     = 1;
      end
    end else if (m_in_debug) begin
      if (regs_exit_dbg) begin
        m_in_debug = 0;
        m_exiting  = 1;
      end
    end else if (m_exiting) begin
      if (!iu_yy_xx_dbgon) begin
        m_exiting = 0;
        m_reason  = 0;
      end
    end
    if (regs_trace_cnt_sel) m_cnt = int'(regs_xx_wdata);
    else if (trace_ctrl_req && idle && m_cnt > 0) m_cnt = m_cnt - 1;
  endtask

  task automatic applyStimulus(input bit tr, input bit sel, input int wd, input bit ex,
                               input bit dn, input string tag);
    @(negedge cpuclk);
    trace_ctrl_req     = tr;
    regs_trace_cnt_sel = sel;
    regs_xx_wdata      = CNT_W'(wd);
    regs_exit_dbg      = ex;
    iu_yy_xx_dbgon     = dn;
    modelStep();
    @(posedge cpuclk);
    #1;
    checkAll(tag);
  endtask

  // Reset is raised between edges so the outputs must fall without a clock.
  task automatic doReset(input string tag);
    @(negedge cpuclk);
    #2;
    cpurst             = 1'b1;
    trace_ctrl_req     = 1'b0;
    regs_trace_cnt_sel = 1'b0;
    regs_xx_wdata      = '0;
    regs_exit_dbg      = 1'b0;
    iu_yy_xx_dbgon     = 1'b0;
    core_dbgon         = 0;
    m_cnt = 0; m_requesting = 0; m_in_debug = 0; m_exiting = 0; m_reason = 0;
    #1;
    checkAll(tag);
    @(negedge cpuclk);
    cpurst = 1'b0;
  endtask

  initial begin
    bit tr, sel, ex, idle;
    int wd;
    cpurst = 1'b0;
    doReset("reset");

    applyStimulus(0, 1, 0, 0, 0, "wr0");
    applyStimulus(0, 0, 0, 0, 0, "idle");
    applyStimulus(1, 0, 0, 0, 0, "hit0");
    applyStimulus(0, 0, 0, 0, 0, "hold_req");
    applyStimulus(0, 0, 0, 0, 1, "dbgon");
    applyStimulus(0, 0, 0, 0, 1, "in_dbg");
    applyStimulus(0, 0, 0, 1, 1, "exit_pulse");
    applyStimulus(0, 0, 0, 0, 1, "exit_wait");
    applyStimulus(0, 0, 0, 0, 0, "exit_done");
    applyStimulus(0, 0, 0, 1, 0, "exit_in_idle");

    applyStimulus(0, 1, 3, 0, 0, "wr3");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 0, 0, "count_pulse");
      applyStimulus(0, 0, 0, 0, 0, "count_gap");
    end
    applyStimulus(1, 0, 0, 0, 0, "no_wrap");
    doReset("reset_in_req");
    applyStimulus(1, 0, 0, 0, 0, "post_reset_hit");
    applyStimulus(0, 0, 0, 0, 1, "post_reset_dbg");
    applyStimulus(0, 0, 0, 1, 1, "post_reset_exit");
    applyStimulus(0, 0, 0, 0, 0, "post_reset_idle");

    applyStimulus(0, 1, 2, 0, 0, "wr2");
    applyStimulus(1, 1, 5, 0, 0, "wr_beats_dec");
    applyStimulus(1, 1, 0, 0, 0, "wr0_with_hit");
    applyStimulus(0, 0, 0, 0, 0, "idle2");

    applyStimulus(0, 1, 4, 0, 0, "wr4");
    applyStimulus(1, 0, 0, 0, 1, "ext_halt");
    applyStimulus(1, 0, 0, 0, 1, "trace_in_dbg");
    applyStimulus(1, 0, 0, 0, 1, "trace_in_dbg2");
    applyStimulus(0, 0, 0, 1, 1, "ext_exit");
    doReset("reset_in_exit");
    applyStimulus(0, 0, 0, 0, 0, "after_reset");

    core_dbgon = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        doReset("rand_reset");
      end else begin
        idle = !(m_requesting || m_in_debug || m_exiting);
        if (m_requesting && $urandom_range(0, 2) == 0) core_dbgon = 1;
        if (m_exiting && $urandom_range(0, 2) == 0) core_dbgon = 0;
        if (idle && $urandom_range(0, 24) == 0) core_dbgon = 1;
        tr  = ($urandom_range(0, 1) == 1);
        sel = ($urandom_range(0, 7) == 0);
        wd  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 4));
        ex  = m_in_debug ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 11) == 0);
        applyStimulus(tr, sel, wd, ex, core_dbgon, "rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
